// File: rtl/vga_coord_fetch_if.sv
// ----------------------------------------------------------------------------
// vga_coord_fetch_if
// Read-port bundle between the coordinate fetcher and the shared-memory
// arbiter/memory.
//   mem_req    fetcher -> memory   read request, held until granted
//   mem_grant  memory  -> fetcher  arbiter grant; accept on req && grant edge
//   mem_addr   fetcher -> memory   read address, valid while mem_req=1
//   mem_rdata  memory  -> fetcher  read data, valid RD_LAT edges after accept
// The master modport is the fetcher side, slave is the memory side.
// ----------------------------------------------------------------------------
interface vga_coord_fetch_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();

   logic              mem_req;
   logic              mem_grant;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_grant,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_grant,
      output mem_rdata
   );

endinterface

// File: rtl/vga_coord_fetch.sv
// ----------------------------------------------------------------------------
// vga_coord_fetch
// Fetches NUM_WORDS sprite coordinate words (monkey x/y, platform-1 x/y,
// platform-2 x/y) from shared memory once per frame_start and presents each
// one to the VGA bit generator for HOLD_CYC cycles, tagged with its index.
//   clk               system clock
//   reset             synchronous active-high reset
//   frame_start       one-cycle pulse that starts a burst
//   mem               memory read port (master side of vga_coord_fetch_if)
//   data_from_mem_vga coordinate word presented to the bit generator
//   vga_counter       word index while presenting, 3'b111 when idle/no-op
//   fetch_busy        high while a burst is in flight
//   fetch_done        one-cycle pulse after the last word's presentation
//   overrun           sticky flag: frame_start arrived while busy
// ----------------------------------------------------------------------------
module vga_coord_fetch #(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 16,
   parameter int                NUM_WORDS = 6,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16'h3F00),
   parameter int                RD_LAT    = 1,
   parameter int                HOLD_CYC  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   vga_coord_fetch_if.master mem,
   output logic [DATA_W-1:0] data_from_mem_vga,
   output logic [2:0]        vga_counter,
   output logic              fetch_busy,
   output logic              fetch_done,
   output logic              overrun
);

   // Counters hold "edges remaining minus one", so the widest value needed
   // is RD_LAT-1 / HOLD_CYC-1.
   localparam int LAT_W  = (RD_LAT   > 1) ? $clog2(RD_LAT)   : 1;
   localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LAT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
   localparam logic [2:0]        LAST_IDX  = 3'(NUM_WORDS - 1);
   localparam logic [2:0]        NO_WORD   = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      PRESENT
   } state_t;

   state_t            state_q;
   logic [2:0]        idx_q;
   logic [LAT_W-1:0]  latCnt_q;
   logic [HOLD_W-1:0] holdCnt_q;
   logic              memReq_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [DATA_W-1:0] data_q;
   logic [2:0]        vgaCnt_q;
   logic              busy_q;
   logic              done_q;
   logic              overrun_q;

   // Word i lives at BASE_ADDR+i; the sum deliberately wraps at 2^ADDR_W so
   // a table placed at the top of memory continues at address 0.
   function automatic logic [ADDR_W-1:0] wordAddr(input logic [2:0] idx);
      return BASE_ADDR + ADDR_W'(idx);
   endfunction

   // Single registered FSM. Every output comes straight from a flop so the
   // bit generator never sees combinational glitches. The address for the
   // next word is loaded on the same edge that enters REQ, so mem_addr is
   // already stable when mem_req rises. vga_counter only carries a real index
   // during PRESENT; everywhere else it reads 7 so the consumer treats the
   // data bus as a no-op, while data_q keeps the last captured word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= 3'd0;
         latCnt_q  <= '0;
         holdCnt_q <= '0;
         memReq_q  <= 1'b0;
         memAddr_q <= '0;
         data_q    <= '0;
         vgaCnt_q  <= NO_WORD;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (frame_start && busy_q) begin
            overrun_q <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (frame_start) begin
                  idx_q     <= 3'd0;
                  memReq_q  <= 1'b1;
                  memAddr_q <= wordAddr(3'd0);
                  busy_q    <= 1'b1;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               if (mem.mem_grant) begin
                  memReq_q <= 1'b0;
                  latCnt_q <= LAT_LOAD;
                  state_q  <= WAIT;
               end
            end
            WAIT: begin
               if (latCnt_q == '0) begin
                  data_q    <= mem.mem_rdata;
                  vgaCnt_q  <= idx_q;
                  holdCnt_q <= HOLD_LOAD;
                  state_q   <= PRESENT;
               end else begin
                  latCnt_q <= latCnt_q - LAT_W'(1);
               end
            end
            PRESENT: begin
               if (holdCnt_q == '0) begin
                  vgaCnt_q <= NO_WORD;
                  if (idx_q == LAST_IDX) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     idx_q     <= idx_q + 3'd1;
                     memReq_q  <= 1'b1;
                     memAddr_q <= wordAddr(idx_q + 3'd1);
                     state_q   <= REQ;
                  end
               end else begin
                  holdCnt_q <= holdCnt_q - HOLD_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem.mem_req        = memReq_q;
   assign mem.mem_addr       = memAddr_q;
   assign data_from_mem_vga  = data_q;
   assign vga_counter        = vgaCnt_q;
   assign fetch_busy         = busy_q;
   assign fetch_done         = done_q;
   assign overrun            = overrun_q;

endmodule

// File: tb/tb_vga_coord_fetch.sv
// ----------------------------------------------------------------------------
// tb_vga_coord_fetch
// Two fetcher instances: A with default parameters, B with BASE_ADDR=FFFE and
// RD_LAT=3. Each burst's expected per-cycle trace is derived from a timeline
// model (request start, grant edge, capture edge, hold window) and compared
// against the DUT every cycle.
// ----------------------------------------------------------------------------
module tb_vga_coord_fetch;

   localparam int          NW     = 6;
   localparam int          HOLD   = 2;
   localparam int          LAT_A  = 1;
   localparam int          LAT_B  = 3;
   localparam logic [15:0] BASE_A = 16'h3F00;
   localparam logic [15:0] BASE_B = 16'hFFFE;
   localparam logic [15:0] POISON = 16'hDEAD;
   localparam int          MAXE   = 200;

   logic        clk = 1'b0;
   logic        reset;
   logic        frameStartA, frameStartB;
   logic [15:0] dataA, dataB;
   logic [2:0]  vgaA, vgaB;
   logic        busyA, busyB, doneA, doneB, ovrA, ovrB;

   logic [15:0] wordsA [0:7];
   logic [15:0] wordsB [0:7];
   logic [15:0] pipeA  [0:LAT_A-1];
   logic [15:0] pipeB  [0:LAT_B-1];

   logic [15:0] lastDataA, lastDataB;
   bit          ovrModelA, ovrModelB;

   int assertCount = 0;
   int failCount   = 0;

   vga_coord_fetch_if #(.ADDR_W(16), .DATA_W(16)) busA ();
   vga_coord_fetch_if #(.ADDR_W(16), .DATA_W(16)) busB ();

   vga_coord_fetch dutA (
      .clk               (clk),
      .reset             (reset),
      .frame_start       (frameStartA),
      .mem               (busA),
      .data_from_mem_vga (dataA),
      .vga_counter       (vgaA),
      .fetch_busy        (busyA),
      .fetch_done        (doneA),
      .overrun           (ovrA)
   );

   vga_coord_fetch #(.BASE_ADDR(16'hFFFE), .RD_LAT(LAT_B)) dutB (
      .clk               (clk),
      .reset             (reset),
      .frame_start       (frameStartB),
      .mem               (busB),
      .data_from_mem_vga (dataB),
      .vga_counter       (vgaB),
      .fetch_busy        (busyB),
      .fetch_done        (doneB),
      .overrun           (ovrB)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Memory contents are an 8-entry table at each instance's base address;
   // anything outside it reads back as a poison value so a wrong address
   // shows up as wrong data.
   function automatic logic [15:0] memWord(input bit useB, input logic [15:0] addr);
      logic [15:0] off;
      off = addr - (useB ? BASE_B : BASE_A);
      if (off < 16'd8) return useB ? wordsB[off[2:0]] : wordsA[off[2:0]];
      return POISON;
   endfunction

   // Read pipelines: data becomes sampleable exactly RD_LAT edges after the
   // accepting edge; at every other time the bus carries poison.
   always @(posedge clk) begin
      pipeA[0] <= (busA.mem_req && busA.mem_grant) ? memWord(1'b0, busA.mem_addr) : POISON;
   end

   always @(posedge clk) begin
      pipeB[0] <= (busB.mem_req && busB.mem_grant) ? memWord(1'b1, busB.mem_addr) : POISON;
      for (int k = 1; k < LAT_B; k++) pipeB[k] <= pipeB[k-1];
   end

   assign busA.mem_rdata = pipeA[LAT_A-1];
   assign busB.mem_rdata = pipeB[LAT_B-1];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit useB, input bit fs, input bit gnt);
      if (useB) begin
         frameStartB    = fs;
         busB.mem_grant = gnt;
         frameStartA    = 1'b0;
      end else begin
         frameStartA    = fs;
         busA.mem_grant = gnt;
         frameStartB    = 1'b0;
      end
   endtask

   task automatic checkReset(input bit useB, input string name);
      checkOutput({name, " rst vga"},  useB ? 32'(vgaB) : 32'(vgaA), 32'd7);
      checkOutput({name, " rst req"},  useB ? 32'(busB.mem_req) : 32'(busA.mem_req), 32'd0);
      checkOutput({name, " rst addr"}, useB ? 32'(busB.mem_addr) : 32'(busA.mem_addr), 32'd0);
      checkOutput({name, " rst busy"}, useB ? 32'(busyB) : 32'(busyA), 32'd0);
      checkOutput({name, " rst done"}, useB ? 32'(doneB) : 32'(doneA), 32'd0);
      checkOutput({name, " rst ovr"},  useB ? 32'(ovrB) : 32'(ovrA), 32'd0);
      checkOutput({name, " rst data"}, useB ? 32'(dataB) : 32'(dataA), 32'd0);
   endtask

   // One burst: frame_start sampled at edge 0. Grant schedule is fixed up
   // front (optionally random, optionally with a forced-low window), then the
   // expected trace is laid out word by word: request from edge s until the
   // first granted edge a>s, capture at a+lat, presentation for HOLD edges,
   // next request at the end of the hold window. fsAgainAt: -1 none, -2 on
   // the fetch_done edge, else an edge number. resetAt: -1 none.
   task automatic runBurst(input bit useB, input string name, input bit randGrant,
                           input int stallFrom, input int stallLen,
                           input int fsAgainAt, input int resetAt);
      bit          g       [0:MAXE];
      bit          expReq  [0:MAXE];
      logic [15:0] expAddr [0:MAXE];
      logic [2:0]  expVga  [0:MAXE];
      int          capEdge [0:NW-1];
      int          lat;
      logic [15:0] base;
      logic [15:0] curData;
      bit          ovrModel;
      int          s, a, c, lastEdge, fsEdge, lastN;
      string       tag;

      lat      = useB ? LAT_B : LAT_A;
      base     = useB ? BASE_B : BASE_A;
      curData  = useB ? lastDataB : lastDataA;
      ovrModel = useB ? ovrModelB : ovrModelA;

      for (int n = 0; n <= MAXE; n++) begin
         g[n] = randGrant ? ($urandom_range(0, 99) < 65) : 1'b1;
         if (n >= stallFrom && n < stallFrom + stallLen) g[n] = 1'b0;
         if (n > 120) g[n] = 1'b1;
         expReq[n]  = 1'b0;
         expAddr[n] = 16'h0;
         expVga[n]  = 3'd7;
      end

      s = 0;
      for (int i = 0; i < NW; i++) begin
         a = s + 1;
         while (!g[a]) a++;
         for (int n = s; n < a; n++) begin
            expReq[n]  = 1'b1;
            expAddr[n] = 16'(base + 16'(i));
         end
         c = a + lat;
         capEdge[i] = c;
         for (int n = c; n < c + HOLD; n++) expVga[n] = 3'(i);
         s = c + HOLD;
      end
      lastEdge = s;
      if (lastEdge + 4 > MAXE) begin
         $display("[TB] FAIL %s timeline too long observed=%0d expected<=%0d", name, lastEdge, MAXE - 4);
         $fatal(1, "[TB] timeline bound exceeded");
      end
      fsEdge = (fsAgainAt == -2) ? lastEdge : fsAgainAt;
      lastN  = (resetAt >= 0) ? resetAt : lastEdge + 2;

      applyStimulus(useB, 1'b1, g[0]);
      for (int n = 0; n <= lastN; n++) begin
         @(negedge clk);
         applyStimulus(useB, (n + 1 == fsEdge), g[n+1]);
         reset = (n + 1 == resetAt);

         if (resetAt >= 0 && n == resetAt) begin
            checkReset(useB, $sformatf("%s n=%0d", name, n));
            lastDataA = 16'h0;
            lastDataB = 16'h0;
            ovrModelA = 1'b0;
            ovrModelB = 1'b0;
            reset = 1'b0;
            applyStimulus(useB, 1'b0, 1'b0);
            return;
         end

         if (n == fsEdge && n >= 1 && n <= lastEdge) ovrModel = 1'b1;
         for (int i = 0; i < NW; i++) begin
            if (n == capEdge[i]) curData = useB ? wordsB[i] : wordsA[i];
         end

         tag = $sformatf("%s n=%0d", name, n);
         checkOutput({tag, " vga"},  useB ? 32'(vgaB) : 32'(vgaA), 32'(expVga[n]));
         checkOutput({tag, " req"},  useB ? 32'(busB.mem_req) : 32'(busA.mem_req), 32'(expReq[n]));
         if (expReq[n])
            checkOutput({tag, " addr"}, useB ? 32'(busB.mem_addr) : 32'(busA.mem_addr), 32'(expAddr[n]));
         checkOutput({tag, " data"}, useB ? 32'(dataB) : 32'(dataA), 32'(curData));
         checkOutput({tag, " busy"}, useB ? 32'(busyB) : 32'(busyA), 32'(n < lastEdge));
         checkOutput({tag, " done"}, useB ? 32'(doneB) : 32'(doneA), 32'(n == lastEdge));
         checkOutput({tag, " ovr"},  useB ? 32'(ovrB) : 32'(ovrA), 32'(ovrModel));
      end

      if (useB) begin
         lastDataB = curData;
         ovrModelB = ovrModel;
      end else begin
         lastDataA = curData;
         ovrModelA = ovrModel;
      end
      applyStimulus(useB, 1'b0, 1'b0);
   endtask

   task automatic loadWords(input bit useB, input bit randomWords);
      for (int i = 0; i < 8; i++) begin
         if (useB) wordsB[i] = randomWords ? 16'($urandom) : 16'(16'h0010 + i);
         else      wordsA[i] = randomWords ? 16'($urandom) : 16'(16'h0010 + i);
      end
   endtask

   // Directed scenarios first, then randomized bursts on both instances.
   initial begin
      int sel, mode, fsAt;

      reset          = 1'b1;
      frameStartA    = 1'b0;
      frameStartB    = 1'b0;
      busA.mem_grant = 1'b0;
      busB.mem_grant = 1'b0;
      lastDataA      = 16'h0;
      lastDataB      = 16'h0;
      ovrModelA      = 1'b0;
      ovrModelB      = 1'b0;
      loadWords(1'b0, 1'b0);
      loadWords(1'b1, 1'b0);

      repeat (3) @(negedge clk);
      $display("[TB] reset held 3 cycles");
      checkReset(1'b0, "A init");
      checkReset(1'b1, "B init");
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] default burst, grant tied high");
      runBurst(1'b0, "A basic", 1'b0, -10, 0, -1, -1);

      $display("[TB] grant held low during word 2");
      runBurst(1'b0, "A stall", 1'b0, 9, 5, -1, -1);

      $display("[TB] frame_start during word 3");
      runBurst(1'b0, "A overrun", 1'b0, -10, 0, 14, -1);
      runBurst(1'b0, "A sticky", 1'b0, -10, 0, -1, -1);

      $display("[TB] reset during word 3 presentation");
      runBurst(1'b0, "A midreset", 1'b0, -10, 0, -1, 15);
      @(negedge clk);
      runBurst(1'b0, "A restart", 1'b0, -10, 0, -1, -1);

      $display("[TB] wrapping base and three-cycle read latency");
      runBurst(1'b1, "B basic", 1'b0, -10, 0, -1, -1);
      runBurst(1'b1, "B donefs", 1'b0, -10, 0, -2, -1);

      $display("[TB] randomized bursts");
      for (int it = 0; it < 8; it++) begin
         sel  = int'($urandom_range(0, 1));
         mode = int'($urandom_range(0, 2));
         fsAt = (mode == 0) ? -1 : (mode == 1) ? -2 : int'($urandom_range(1, 20));
         loadWords(sel[0], 1'b1);
         runBurst(sel[0], $sformatf("rand%0d", it), 1'b1, -10, 0, fsAt, -1);
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
